seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side monitor for the multiplexed four-digit seven-segment display port driven by the hanoi top level. It samples the active-low `seg`/`an` scan outputs and filters out scan-transition glitches. It decodes each refreshed digit back to a 4-bit hex value with valid, blank and decimal-point flags, and reports frame completion, malformed patterns and scan stalls. It sits in the bench or on-chip debug path opposite the display driver, so checks compare numbers rather than segment bits.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical synchronized samples required before a pattern is accepted; legal range 2–255.
- `TIMEOUT_CYCLES`, 4096: cycles without any accepted digit before all captured state is invalidated; legal range 16–2^20.
- `msclk` in 1: sole clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `seg` in 8: active-low segments; [0]=a … [6]=g, [7]=dp.
- `an` in 4: active-low digit enables; [0]=rightmost digit.
- `digits` out 16: captured hex values; digit n in [4n+3:4n].
- `dig_valid` out 4: digit n holds a decoded value or blank.
- `blank` out 4: digit n was captured with all segments off.
- `dp` out 4: captured decimal point, 1 = lit.
- `frame_done` out 1: one-cycle pulse when all four digits have been captured since the last pulse.
- `err` out 1: one-cycle pulse on an accepted malformed pattern.
- `timeout` out 1: one-cycle pulse when `TIMEOUT_CYCLES` elapse with no accepted digit.

## Operation
- Input path: `{an,seg}` passes through a 2-flop synchronizer, then into a compare register holding the previous sample.
- Stability counter:
  - Clears when the new sample differs from the previous one.
  - Otherwise increments, saturating at `STABLE_CYCLES`.
  - Exactly one accept strobe fires, on the cycle the count first reaches `STABLE_CYCLES-1` (i.e. `STABLE_CYCLES` identical samples).
  - A held pattern is accepted only once.
- Classification on accept:
  - `an`==4'hF: idle. No state change, no pulse.
  - `an` has exactly one zero at index n, and `seg[6:0]` matches the hex table: `digits[n]`←value, `dig_valid[n]`←1, `blank[n]`←0, `dp[n]`←~`seg[7]`.
  - `an` one-hot-low and `seg[6:0]`==7'h7F: `dig_valid[n]`←1, `blank[n]`←1, `digits[n]`←0, `dp[n]` captured as above.
  - `an` one-hot-low with an unmatched `seg` pattern: `err` pulse, `dig_valid[n]`←0, `blank[n]`←0.
  - Two or more zeros in `an`: `err` pulse, no digit state changes.
- Hex table (`seg[6:0]` → value): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
- Frame tracking:
  - `seen[3:0]` sets bit n on each valid or blank capture.
  - When `seen` becomes 4'hF, `frame_done` pulses and `seen` clears in the same cycle.
  - Re-capturing an already-seen digit only overwrites its value.
- Timeout:
  - The idle counter clears on every accept strobe (any class) and otherwise increments.
  - When it reaches `TIMEOUT_CYCLES-1`: `timeout` pulses, `dig_valid`/`blank`/`seen` clear, the counter restarts from 0.
  - `digits` and `dp` keep their values.
- Reset values: `digits`=0, `dig_valid`=0, `blank`=0, `dp`=0, `frame_done`=0, `err`=0, `timeout`=0; synchronizer and compare register=all ones (idle pattern); counters=0.

## Timing
- Latency: an input pattern held from cycle k updates outputs at the registered edge of cycle k+2+`STABLE_CYCLES`.
- All outputs are registered. Pulses are exactly one cycle wide.
- The pulse cycle for `frame_done` equals the update cycle of the completing digit.
- A pattern held for fewer than `STABLE_CYCLES` samples is discarded without side effect.
- Accept and timeout in the same cycle: the accept wins; the counter clears and no `timeout` is issued.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). The first accept after release needs a full `STABLE_CYCLES` run.

## Configuration
- `SEG_SCAN_DP_EN` defined: `seg[7]` takes part in stability compare and is captured into `dp`.
- `SEG_SCAN_DP_EN` undefined:
  - `seg[7]` is ignored entirely; a dp toggle neither resets stability nor changes state.
  - `dp` is tied to 4'b0000.

## Test plan
- Reset, then drive idle (`an`=F) for 100 cycles → all outputs 0, no pulses.
- Scan "1A3F" (digit3..0) with `an` rotating E,D,B,7, 16 cycles per digit → `digits`=16'h1A3F, `dig_valid`=F, one `frame_done` per full rotation.
- Hold each pattern for only `STABLE_CYCLES-1` cycles → no updates, no pulses.
- Drive `an`=4'hC, then `an`=E with `seg`=7'h7E → `err` pulses twice; `dig_valid[0]` clears only on the second.
- Digit 2 shows `seg`=7'h7F with dp lit (`seg[7]`=0) → `blank[2]`=1, `dig_valid[2]`=1, `dp[2]`=1 (0 when the macro is undefined).
- After a full frame, hold `an`=F for `TIMEOUT_CYCLES` → single `timeout` pulse, `dig_valid`=0, `digits` unchanged; assert `rst_n` mid-scan → immediate zeroing.

Source files
------------

// File: rtl/seg_scan_if.sv
// Bundles the seven-segment scan port (seg/an) with the decoded monitor
// results of seg_scan_decoder.
//   master : the display-driver side (drives seg/an, observes results)
//   slave  : the decoder (samples seg/an, drives results)
// Signals:
//   seg[7:0]      active-low segments, [0]=a .. [6]=g, [7]=dp
//   an[3:0]       active-low digit enables, [0]=rightmost
//   digits[15:0]  captured hex values, digit n in [4n+3:4n]
//   dig_valid/blank/dp[3:0]  per-digit capture flags
//   frame_done/err/timeout   one-cycle pulses
interface seg_scan_if;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  dig_valid;
  logic [3:0]  blank;
  logic [3:0]  dp;
  logic        frame_done;
  logic        err;
  logic        timeout;

  modport master (output seg, an,
                  input  digits, dig_valid, blank, dp, frame_done, err, timeout);
  modport slave  (input  seg, an,
                  output digits, dig_valid, blank, dp, frame_done, err, timeout);
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive-side monitor for a 4-digit multiplexed
// seven-segment scan port. Synchronizes {an,seg}, accepts a pattern after
// STABLE_CYCLES identical samples, decodes it back to hex with valid /
// blank / dp flags, and reports frame completion, malformed patterns and
// scan stalls.
// Ports:
//   msclk  : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : seg_scan_if.slave (seg/an in, decoded results out)
// Parameters:
//   STABLE_CYCLES  (2..255)   identical samples needed to accept a pattern
//   TIMEOUT_CYCLES (16..2^20) cycles without an accept before invalidation
// Configuration macro:
//   SEG_SCAN_DP_EN : when defined, seg[7] joins the stability compare and is
//                    captured into dp; otherwise seg[7] is ignored and dp=0.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic      msclk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  // seg -> {value_hit, value}
  function automatic logic [4:0] hex_dec(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40: r = 5'h10; 7'h79: r = 5'h11; 7'h24: r = 5'h12; 7'h30: r = 5'h13;
      7'h19: r = 5'h14; 7'h12: r = 5'h15; 7'h02: r = 5'h16; 7'h78: r = 5'h17;
      7'h00: r = 5'h18; 7'h10: r = 5'h19; 7'h08: r = 5'h1A; 7'h03: r = 5'h1B;
      7'h46: r = 5'h1C; 7'h21: r = 5'h1D; 7'h06: r = 5'h1E; 7'h0E: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [11:0] w_in;
`ifdef SEG_SCAN_DP_EN
  assign w_in = {bus.an, bus.seg};
`else
  // Forcing dp to "off" removes it from both compare and capture.
  assign w_in = {bus.an, bus.seg | 8'h80};
`endif

  logic [11:0]   r_sync1, r_sync2, r_prev;
  logic [SW-1:0] r_stab;
  logic [TW-1:0] r_idle, w_idle_n;
  logic [15:0]   r_digits, w_digits_n;
  logic [3:0]    r_valid, w_valid_n;
  logic [3:0]    r_blank, w_blank_n;
  logic [3:0]    r_dp, w_dp_n;
  logic [3:0]    r_seen, w_seen_n;
  logic          r_frame, w_frame_n;
  logic          r_err, w_err_n;
  logic          r_tout, w_tout_n;

  logic       w_same, w_accept, w_onehot;
  logic [3:0] w_an;
  logic [7:0] w_seg;
  logic [1:0] w_idx;
  logic [4:0] w_dec;

  assign w_same   = (r_sync2 == r_prev);
  // Count S-2 -> S-1 is the S-th identical sample; saturation past it
  // guarantees a held pattern is accepted only once.
  assign w_accept = w_same && (r_stab == SW'(STABLE_CYCLES - 2));
  assign w_an     = r_sync2[11:8];
  assign w_seg    = r_sync2[7:0];
  assign w_onehot = $onehot(~w_an);
  assign w_dec    = hex_dec(w_seg[6:0]);

  always_comb begin
    w_idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!w_an[i]) w_idx = 2'(i);
  end

  always_ff @(posedge msclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
      r_stab  <= '0;
    end else begin
      r_sync1 <= w_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (!w_same)                            r_stab <= '0;
      else if (r_stab != SW'(STABLE_CYCLES))  r_stab <= r_stab + 1'b1;
    end
  end

  always_comb begin
    w_digits_n = r_digits;
    w_valid_n  = r_valid;
    w_blank_n  = r_blank;
    w_dp_n     = r_dp;
    w_seen_n   = r_seen;
    w_frame_n  = 1'b0;
    w_err_n    = 1'b0;
    w_tout_n   = 1'b0;
    w_idle_n   = r_idle + 1'b1;
    if (w_accept) begin
      // An accept in the timeout cycle wins: counter clears, no timeout.
      w_idle_n = '0;
      if (w_an != 4'hF) begin
        if (!w_onehot) begin
          w_err_n = 1'b1;
        end else if (w_dec[4] || w_seg[6:0] == 7'h7F) begin
          w_digits_n[{w_idx, 2'b00} +: 4] = w_dec[4] ? w_dec[3:0] : 4'h0;
          w_valid_n[w_idx] = 1'b1;
          w_blank_n[w_idx] = !w_dec[4];
`ifdef SEG_SCAN_DP_EN
          w_dp_n[w_idx]    = !w_seg[7];
`endif
          w_seen_n[w_idx]  = 1'b1;
        end else begin
          w_err_n          = 1'b1;
          w_valid_n[w_idx] = 1'b0;
          w_blank_n[w_idx] = 1'b0;
        end
      end
    end else if (r_idle == TW'(TIMEOUT_CYCLES - 1)) begin
      w_tout_n  = 1'b1;
      w_valid_n = '0;
      w_blank_n = '0;
      w_seen_n  = '0;
      w_idle_n  = '0;
    end
    if (w_seen_n == 4'hF) begin
      w_frame_n = 1'b1;
      w_seen_n  = '0;
    end
  end

  always_ff @(posedge msclk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle   <= '0;
      r_digits <= '0;
      r_valid  <= '0;
      r_blank  <= '0;
      r_dp     <= '0;
      r_seen   <= '0;
      r_frame  <= 1'b0;
      r_err    <= 1'b0;
      r_tout   <= 1'b0;
    end else begin
      r_idle   <= w_idle_n;
      r_digits <= w_digits_n;
      r_valid  <= w_valid_n;
      r_blank  <= w_blank_n;
      r_dp     <= w_dp_n;
      r_seen   <= w_seen_n;
      r_frame  <= w_frame_n;
      r_err    <= w_err_n;
      r_tout   <= w_tout_n;
    end
  end

  assign bus.digits     = r_digits;
  assign bus.dig_valid  = r_valid;
  assign bus.blank      = r_blank;
  assign bus.dp         = r_dp;
  assign bus.frame_done = r_frame;
  assign bus.err        = r_err;
  assign bus.timeout    = r_tout;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: each driven pattern pushes the
// expected decoder state onto a scoreboard queue; the entry is popped and
// compared once the pattern has been held long enough to take effect.
module tb_seg_scan_decoder;

  localparam int S = 4;
  localparam int T = 4096;

  logic msclk = 1'b0;
  logic rst_n = 1'b1;
  always #5 msclk = ~msclk;

  seg_scan_if bus();

  seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .msclk (msclk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  valid, blank, dp;
    int          frames, errs, touts;
    string       tag;
  } exp_t;

  exp_t q[$];

  int n_assert = 0;
  int n_fail   = 0;

  // pulse-cycle counters seen on the DUT outputs
  int n_frame = 0, n_err = 0, n_tout = 0;
  always @(negedge msclk) if (rst_n) begin
    n_frame += int'(bus.frame_done);
    n_err   += int'(bus.err);
    n_tout  += int'(bus.timeout);
  end

  // reference model state
  logic [15:0] m_digits;
  logic [3:0]  m_valid, m_blank, m_dp, m_seen;
  int          m_frames, m_errs, m_touts;

  logic [6:0] HEX [16];
  initial HEX = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic model_reset();
    m_digits = '0; m_valid = '0; m_blank = '0; m_dp = '0; m_seen = '0;
  endtask

  task automatic model_accept(input logic [3:0] an, input logic [7:0] seg);
    int zeros, n, v;
    if (an == 4'hF) return;
    zeros = 0; n = 0;
    for (int i = 0; i < 4; i++) if (an[i] == 1'b0) begin zeros++; n = i; end
    if (zeros != 1) begin m_errs++; return; end
    v = -1;
    for (int i = 0; i < 16; i++) if (HEX[i] == seg[6:0]) v = i;
    if (v >= 0 || seg[6:0] == 7'h7F) begin
      m_digits[n*4 +: 4] = (v >= 0) ? 4'(v) : 4'h0;
      m_valid[n] = 1'b1;
      m_blank[n] = (v < 0);
`ifdef SEG_SCAN_DP_EN
      m_dp[n] = ~seg[7];
`endif
      m_seen[n] = 1'b1;
      if (m_seen == 4'hF) begin m_frames++; m_seen = '0; end
    end else begin
      m_errs++;
      m_valid[n] = 1'b0;
      m_blank[n] = 1'b0;
    end
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.digits = m_digits; e.valid = m_valid; e.blank = m_blank; e.dp = m_dp;
    e.frames = m_frames; e.errs = m_errs; e.touts = m_touts; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    e = q.pop_front();
    chk({e.tag, ".digits"}, 32'(bus.digits),    32'(e.digits));
    chk({e.tag, ".valid"},  32'(bus.dig_valid), 32'(e.valid));
    chk({e.tag, ".blank"},  32'(bus.blank),     32'(e.blank));
    chk({e.tag, ".dp"},     32'(bus.dp),        32'(e.dp));
    chk({e.tag, ".frames"}, 32'(n_frame),       32'(e.frames));
    chk({e.tag, ".errs"},   32'(n_err),         32'(e.errs));
    chk({e.tag, ".touts"},  32'(n_tout),        32'(e.touts));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".digits"}, 32'(bus.digits), 32'h0);
    chk({tag, ".valid"},  32'(bus.dig_valid), 32'h0);
    chk({tag, ".blank"},  32'(bus.blank), 32'h0);
    chk({tag, ".dp"},     32'(bus.dp), 32'h0);
    chk({tag, ".pulses"}, 32'({bus.frame_done, bus.err, bus.timeout}), 32'h0);
  endtask

  // Drive a pattern at a negedge and hold it for 'hold' clock cycles.
  // Patterns held fewer than S cycles must be discarded.
  task automatic show(input logic [3:0] an, input logic [7:0] seg,
                      input int hold, input bit tout, input string tag);
    bus.an = an; bus.seg = seg;
    if (hold >= S) model_accept(an, seg);
    if (tout) begin m_valid = '0; m_blank = '0; m_seen = '0; m_touts++; end
    push(tag);
    repeat (hold) @(negedge msclk);
    pop_check();
  endtask

  initial begin
    bus.an = 4'hF; bus.seg = 8'hFF;
    model_reset(); m_frames = 0; m_errs = 0; m_touts = 0;
    #1 rst_n = 1'b0;
    #20 chk_zero("reset");
    @(negedge msclk) rst_n = 1'b1;

    show(4'hF, 8'hFF, 100, 1'b0, "idle");

    // "1A3F", two full rotations
    for (int r = 0; r < 2; r++) begin
      show(4'hE, 8'h8E, 16, 1'b0, "scanF");
      show(4'hD, 8'hB0, 16, 1'b0, "scan3");
      show(4'hB, 8'h88, 16, 1'b0, "scanA");
      show(4'h7, 8'hF9, 16, 1'b0, "scan1");
    end
    chk("scan.digits", 32'(bus.digits), 32'h1A3F);

    // short holds must not change anything
    show(4'hE, 8'hC0, S-1, 1'b0, "short0");
    show(4'hD, 8'h99, S-1, 1'b0, "short1");
    show(4'hB, 8'hA4, S-1, 1'b0, "short2");
    show(4'h7, 8'h86, S-1, 1'b0, "short3");
    show(4'hF, 8'hFF, 16, 1'b0, "short_idle");

    // malformed: two enables, then unknown segment pattern on digit 0
    show(4'hC, 8'h8E, 16, 1'b0, "err_multi");
    chk("err_multi.v0", 32'(bus.dig_valid[0]), 32'h1);
    show(4'hE, 8'hFE, 16, 1'b0, "err_seg");

    // blank digit 2 with dp lit
    show(4'hB, 8'h7F, 16, 1'b0, "blank2");

    // finish a frame, then stall for the timeout
    show(4'hE, 8'h12, 16, 1'b0, "f5");
    show(4'hD, 8'h46, 16, 1'b0, "fC");
    show(4'h7, 8'h21, 16, 1'b0, "fd");
    show(4'hF, 8'hFF, T + 40, 1'b1, "tout");

    // latency: update exactly S+2 edges after the pattern appears
    bus.an = 4'hE; bus.seg = 8'h80;
    repeat (S + 1) @(negedge msclk);
    chk("lat.before", 32'(bus.dig_valid), 32'h0);
    @(negedge msclk);
    chk("lat.after", 32'(bus.dig_valid), 32'h1);
    model_accept(4'hE, 8'h80);
    show(4'hE, 8'h80, 10, 1'b0, "lat8");

    // asynchronous reset mid-scan
    bus.an = 4'hD; bus.seg = 8'hB0;
    repeat (8) @(negedge msclk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    model_reset();
    @(negedge msclk) rst_n = 1'b1;
    repeat (S + 1) @(negedge msclk);
    chk("rel.before", 32'(bus.dig_valid), 32'h0);
    @(negedge msclk);
    chk("rel.after", 32'(bus.dig_valid), 32'h2);
    model_accept(4'hD, 8'hB0);
    show(4'hD, 8'hB0, 10, 1'b0, "rel3");

    chk("queue.empty", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
